// File: rtl/memory_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter and the top-level memory decode.
package memory_port_arbiter_pkg;

    // Requester identifiers; also the bit index into req_valid/req_ready/resp_valid.
    localparam logic REQ_CORE  = 1'b0;
    localparam logic REQ_DEBUG = 1'b1;

    // Bit positions inside the 3-bit write-sections field.
    localparam int unsigned SECTION_BYTE0 = 0;
    localparam int unsigned SECTION_BYTE1 = 1;
    localparam int unsigned SECTION_UPPER = 2;

    typedef logic [2:0] sections_t;

    // Memory-mapped register addresses; everything outside this window is block RAM.
    localparam logic [31:0] MMIO_BASE       = 32'h8000_0000;
    localparam logic [31:0] MTIME_ADDR      = 32'h8000_0000;
    localparam logic [31:0] MTIMEH_ADDR     = 32'h8000_0004;
    localparam logic [31:0] MTIMECMP_ADDR   = 32'h8000_0008;
    localparam logic [31:0] MTIMECMPH_ADDR  = 32'h8000_000C;
    localparam logic [31:0] LED_ADDR        = 32'h8000_0010;

    // Lock FSM encoding.
    localparam logic [0:0] LOCK_UNLOCKED = 1'b0;
    localparam logic [0:0] LOCK_LOCKED   = 1'b1;

    // The requester that is not 'id'.
    function automatic logic other_req(input logic id);
        return ~id;
    endfunction

    // True when an address lands in the timer/LED register window.
    function automatic logic is_mmio_addr(input logic [31:0] addr);
        return addr[31:28] == MMIO_BASE[31:28];
    endfunction

endpackage

// File: rtl/memory_port_arbiter_if.sv
// Requester-side bus of the memory port arbiter: both request channels plus grant/response.
interface memory_port_arbiter_if;
    import memory_port_arbiter_pkg::*;

    logic [1:0]  req_valid;
    logic [1:0]  req_lock;
    logic [31:0] req_address0;
    logic [31:0] req_address1;
    logic [31:0] req_write_value0;
    logic [31:0] req_write_value1;
    sections_t   req_write_sections0;
    sections_t   req_write_sections1;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [31:0] resp_read_value;

    // Requesters (core LSU, debug/loader) drive requests and observe grants/responses.
    modport master (
        output req_valid, req_lock,
        output req_address0, req_address1,
        output req_write_value0, req_write_value1,
        output req_write_sections0, req_write_sections1,
        input  req_ready, resp_valid, resp_read_value
    );

    // The arbiter consumes requests and produces grants/responses.
    modport slave (
        input  req_valid, req_lock,
        input  req_address0, req_address1,
        input  req_write_value0, req_write_value1,
        input  req_write_sections0, req_write_sections1,
        output req_ready, resp_valid, resp_read_value
    );

endinterface

// File: rtl/memory_port_arbiter_round_robin_select.sv
// Combinational grant choice for two requesters: lock owner first, then round-robin.
module memory_port_arbiter_round_robin_select
    import memory_port_arbiter_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    input  logic       lock_active_i,
    input  logic       lock_owner_i,
    input  logic       limit_hit_i,
    output logic [1:0] grant_o
);

    logic [1:0] owner_onehot;
    logic [1:0] other_onehot;

    assign owner_onehot = lock_owner_i ? 2'b10 : 2'b01;
    assign other_onehot = other_req(lock_owner_i) ? 2'b10 : 2'b01;

    // Pick at most one requester; limit_hit already implies the other requester is valid.
    always_comb begin
        grant_o = 2'b00;
        if (lock_active_i && valid_i[lock_owner_i] && !limit_hit_i) begin
            grant_o = owner_onehot;
        end else if (limit_hit_i) begin
            grant_o = other_onehot;
        end else begin
            unique case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Two-requester arbiter for the single data-memory port, with bounded lock and
// one-cycle registered response.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_LOCK_BEATS = 4,
    parameter logic [31:0] IDLE_ADDRESS   = 32'h0000_0000
) (
    input  logic                   clk24,
    input  logic                   reset_n,
    memory_port_arbiter_if.slave   bus,
    output logic [31:0]            memory_address,
    output logic [31:0]            memory_write_value,
    output sections_t              memory_write_sections,
    input  logic [31:0]            memory_read_value
);

    localparam logic [3:0] MaxBeats = 4'(MAX_LOCK_BEATS);

    logic       last_grant_q, last_grant_d;
    logic [0:0] lock_state_q, lock_state_d;
    logic       lock_owner_q, lock_owner_d;
    logic [3:0] lock_count_q, lock_count_d;
    logic       pending_valid_q, pending_valid_d;
    logic       pending_id_q, pending_id_d;

    logic       lock_active;
    logic       limit_hit;
    logic [1:0] grant;
    logic       any_transfer;
    logic       grant_id;

    assign lock_active = (lock_state_q == LOCK_LOCKED);

    // Owner has used its full budget while the other side is waiting.
    assign limit_hit = lock_active && (lock_count_q == MaxBeats)
                       && bus.req_valid[other_req(lock_owner_q)];

    memory_port_arbiter_round_robin_select u_round_robin_select (
        .valid_i       (bus.req_valid),
        .last_grant_i  (last_grant_q),
        .lock_active_i (lock_active),
        .lock_owner_i  (lock_owner_q),
        .limit_hit_i   (limit_hit),
        .grant_o       (grant)
    );

    // Grant is only ever raised for a valid requester, so any grant is a transfer.
    assign bus.req_ready = grant;
    assign any_transfer  = |grant;
    assign grant_id      = grant[1];

    // Route the granted request downstream; park on a RAM address when idle so no
    // timer register ever sees a spurious access.
    always_comb begin
        memory_address        = IDLE_ADDRESS;
        memory_write_value    = 32'h0;
        memory_write_sections = '0;
        unique case (grant)
            2'b01: begin
                memory_address        = bus.req_address0;
                memory_write_value    = bus.req_write_value0;
                memory_write_sections = bus.req_write_sections0;
            end
            2'b10: begin
                memory_address        = bus.req_address1;
                memory_write_value    = bus.req_write_value1;
                memory_write_sections = bus.req_write_sections1;
            end
            default: ;
        endcase
    end

    // Round-robin pointer and pending-response bookkeeping.
    always_comb begin
        last_grant_d    = any_transfer ? grant_id : last_grant_q;
        pending_valid_d = any_transfer;
        pending_id_d    = any_transfer ? grant_id : pending_id_q;
    end

    // Lock FSM: a locked owner keeps the port until it drops valid/lock or is starved out.
    always_comb begin
        lock_state_d = lock_state_q;
        lock_owner_d = lock_owner_q;
        lock_count_d = lock_count_q;
        case (lock_state_q)
            LOCK_UNLOCKED: begin
                if (any_transfer && bus.req_lock[grant_id]) begin
                    lock_state_d = LOCK_LOCKED;
                    lock_owner_d = grant_id;
                    lock_count_d = 4'd1;
                end
            end
            LOCK_LOCKED: begin
                if (!bus.req_valid[lock_owner_q] || limit_hit) begin
                    lock_state_d = LOCK_UNLOCKED;
                    lock_count_d = 4'd0;
                end else if (bus.req_lock[lock_owner_q]) begin
                    // Owner is granted here; count saturates so a later waiter trips the limit.
                    if (lock_count_q != MaxBeats) begin
                        lock_count_d = lock_count_q + 4'd1;
                    end
                end else begin
                    lock_state_d = LOCK_UNLOCKED;
                    lock_count_d = 4'd0;
                end
            end
            default: begin
                lock_state_d = LOCK_UNLOCKED;
                lock_count_d = 4'd0;
            end
        endcase
    end

    // State registers; reset drops any response still in flight.
    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q    <= REQ_DEBUG;
            lock_state_q    <= LOCK_UNLOCKED;
            lock_owner_q    <= REQ_CORE;
            lock_count_q    <= 4'd0;
            pending_valid_q <= 1'b0;
            pending_id_q    <= REQ_CORE;
        end else begin
            last_grant_q    <= last_grant_d;
            lock_state_q    <= lock_state_d;
            lock_owner_q    <= lock_owner_d;
            lock_count_q    <= lock_count_d;
            pending_valid_q <= pending_valid_d;
            pending_id_q    <= pending_id_d;
        end
    end

    // Response pulse for the requester granted last cycle; read data is a passthrough.
    always_comb begin
        bus.resp_valid = 2'b00;
        if (pending_valid_q) begin
            bus.resp_valid = pending_id_q ? 2'b10 : 2'b01;
        end
    end

    assign bus.resp_read_value = memory_read_value;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: scenario tasks plus a response scoreboard.
module tb_memory_port_arbiter;
    import memory_port_arbiter_pkg::*;

    localparam logic [31:0] IDLE = 32'h0000_0000;

    logic        clk24;
    logic        reset_n;
    logic [31:0] memory_address;
    logic [31:0] memory_write_value;
    logic [2:0]  memory_write_sections;
    logic [31:0] memory_read_value = 32'h0;

    memory_port_arbiter_if bus ();

    memory_port_arbiter #(
        .MAX_LOCK_BEATS (4),
        .IDLE_ADDRESS   (IDLE)
    ) dut (
        .clk24                 (clk24),
        .reset_n               (reset_n),
        .bus                   (bus),
        .memory_address        (memory_address),
        .memory_write_value    (memory_write_value),
        .memory_write_sections (memory_write_sections),
        .memory_read_value     (memory_read_value)
    );

    initial clk24 = 1'b0;
    always #5 clk24 = ~clk24;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // Memory contents as seen by the bench.
    function automatic logic [31:0] mem_value(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEADBEEF;
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // One-cycle read latency downstream model.
    always @(posedge clk24) memory_read_value <= mem_value(memory_address);

    // Scoreboard: every response pulse must match the oldest expected transfer.
    always @(negedge clk24) begin
        if (bus.resp_valid !== 2'b00) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL resp_unexpected: got resp_valid=%b, required no response", bus.resp_valid);
            end else begin
                mon_e = sb_q.pop_front();
                if (bus.resp_valid !== (mon_e.id ? 2'b10 : 2'b01)
                    || bus.resp_read_value !== mon_e.data) begin
                    n_errors++;
                    $display("FAIL resp_match: got valid=%b data=%h, required valid=%b data=%h",
                             bus.resp_valid, bus.resp_read_value,
                             (mon_e.id ? 2'b10 : 2'b01), mon_e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk24);
        #1;
    endtask

    task automatic set_req(input int id, input logic v, input logic lk, input logic [31:0] a,
                           input logic [31:0] w, input logic [2:0] s);
        if (id == 0) begin
            bus.req_valid[0] = v;  bus.req_lock[0] = lk;
            bus.req_address0 = a;  bus.req_write_value0 = w;  bus.req_write_sections0 = s;
        end else begin
            bus.req_valid[1] = v;  bus.req_lock[1] = lk;
            bus.req_address1 = a;  bus.req_write_value1 = w;  bus.req_write_sections1 = s;
        end
    endtask

    task automatic clear_reqs();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    task automatic push_exp(input logic id, input logic [31:0] addr);
        exp_t e;
        e.id   = id;
        e.data = mem_value(addr);
        sb_q.push_back(e);
    endtask

    task automatic apply_reset();
        clear_reqs();
        reset_n = 1'b0;
        step();
        step();
        #2 reset_n = 1'b1;
        @(posedge clk24);
        #1;
    endtask

    // Let outstanding responses drain, then require the scoreboard to be empty.
    task automatic drain(input string name);
        clear_reqs();
        step();
        step();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_drain: got %0d responses missing, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        clear_reqs();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.resp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_outputs: got resp_valid=%b req_ready=%b, required 00/00",
                     bus.resp_valid, bus.req_ready);
        end
        n_checks++;
        if (memory_address !== IDLE || memory_write_sections !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_idle_bus: got addr=%h sect=%b, required %h/000",
                     memory_address, memory_write_sections, IDLE);
        end
        @(posedge clk24);
        #3 reset_n = 1'b1;
        @(posedge clk24);
        #1;
        // Transfer, then reset while its response is pending; nothing is pushed.
        set_req(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 3'b000);
        step();
        reset_n = 1'b0;
        clear_reqs();
        #1;
        n_checks++;
        if (bus.resp_valid !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_drop: got resp_valid=%b, required 00", bus.resp_valid);
        end
        step();
        step();
        #2 reset_n = 1'b1;
        @(posedge clk24);
        #1;
        set_req(0, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 3'b000);
        set_req(1, 1'b1, 1'b0, 32'h0000_0034, 32'h0, 3'b000);
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b01) begin
            n_errors++;
            $display("FAIL reset_first_tie: got req_ready=%b, required 01", bus.req_ready);
        end
        push_exp(1'b0, 32'h0000_0030);
        step();
        drain("reset");
    endtask

    task automatic test_single_read();
        apply_reset();
        set_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 3'b000);
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b01 || memory_address !== 32'h0000_0010) begin
            n_errors++;
            $display("FAIL single_grant: got ready=%b addr=%h, required 01/00000010",
                     bus.req_ready, memory_address);
        end
        push_exp(1'b0, 32'h0000_0010);
        step();
        clear_reqs();
        #1;
        n_checks++;
        if (bus.resp_valid !== 2'b01 || bus.resp_read_value !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL single_resp: got valid=%b data=%h, required 01/deadbeef",
                     bus.resp_valid, bus.resp_read_value);
        end
        drain("single");
    endtask

    task automatic test_round_robin();
        logic [1:0]  want;
        logic [31:0] want_addr;
        apply_reset();
        set_req(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 3'b000);
        set_req(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 3'b000);
        for (int i = 0; i < 6; i++) begin
            #1;
            want      = (i % 2 == 0) ? 2'b01 : 2'b10;
            want_addr = (i % 2 == 0) ? 32'h0000_0200 : 32'h0000_0300;
            n_checks++;
            if (bus.req_ready !== want || memory_address !== want_addr) begin
                n_errors++;
                $display("FAIL rr_cycle%0d: got ready=%b addr=%h, required %b/%h",
                         i, bus.req_ready, memory_address, want, want_addr);
            end
            push_exp(want[1], want_addr);
            step();
        end
        drain("rr");
    endtask

    task automatic test_lock();
        apply_reset();
        set_req(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b000);
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b01) begin
            n_errors++;
            $display("FAIL lock_pre: got ready=%b, required 01", bus.req_ready);
        end
        push_exp(1'b0, 32'h0000_0100);
        step();
        set_req(1, 1'b1, 1'b1, MTIME_ADDR, 32'h0, 3'b000);
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b10 || memory_address !== MTIME_ADDR) begin
            n_errors++;
            $display("FAIL lock_beat1: got ready=%b addr=%h, required 10/%h",
                     bus.req_ready, memory_address, MTIME_ADDR);
        end
        push_exp(1'b1, MTIME_ADDR);
        step();
        set_req(1, 1'b1, 1'b0, MTIMEH_ADDR, 32'h0, 3'b000);
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b10 || memory_address !== MTIMEH_ADDR) begin
            n_errors++;
            $display("FAIL lock_beat2: got ready=%b addr=%h, required 10/%h",
                     bus.req_ready, memory_address, MTIMEH_ADDR);
        end
        push_exp(1'b1, MTIMEH_ADDR);
        step();
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b01 || memory_address !== 32'h0000_0100) begin
            n_errors++;
            $display("FAIL lock_release: got ready=%b addr=%h, required 01/00000100",
                     bus.req_ready, memory_address);
        end
        push_exp(1'b0, 32'h0000_0100);
        step();
        drain("lock");
    endtask

    task automatic test_starvation();
        logic [1:0] want;
        apply_reset();
        set_req(0, 1'b1, 1'b1, 32'h0000_0400, 32'h0, 3'b000);
        set_req(1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 3'b000);
        // Four locked beats, forced hand-over, then requester 0 wins the fresh tie.
        for (int i = 0; i < 6; i++) begin
            #1;
            want = (i == 4) ? 2'b10 : 2'b01;
            n_checks++;
            if (bus.req_ready !== want) begin
                n_errors++;
                $display("FAIL starve_cycle%0d: got ready=%b, required %b", i + 1, bus.req_ready, want);
            end
            push_exp(want[1], want[1] ? 32'h0000_0500 : 32'h0000_0400);
            step();
        end
        drain("starve");
    endtask

    task automatic test_saturation();
        apply_reset();
        set_req(0, 1'b1, 1'b1, 32'h0000_0700, 32'h0, 3'b000);
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (bus.req_ready !== 2'b01) begin
                n_errors++;
                $display("FAIL sat_owner%0d: got ready=%b, required 01", i, bus.req_ready);
            end
            push_exp(1'b0, 32'h0000_0700);
            step();
        end
        // Saturated count: the newcomer must be granted immediately.
        set_req(1, 1'b1, 1'b0, 32'h0000_0780, 32'h0, 3'b000);
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b10) begin
            n_errors++;
            $display("FAIL sat_handover: got ready=%b, required 10", bus.req_ready);
        end
        push_exp(1'b1, 32'h0000_0780);
        step();
        drain("sat");
    endtask

    task automatic test_idle_write();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (memory_address !== IDLE || memory_write_sections !== 3'b000
                || memory_write_value !== 32'h0 || bus.req_ready !== 2'b00) begin
                n_errors++;
                $display("FAIL idle_cycle%0d: got addr=%h sect=%b wval=%h ready=%b, required %h/000/0/00",
                         i, memory_address, memory_write_sections, memory_write_value,
                         bus.req_ready, IDLE);
            end
            step();
        end
        set_req(1, 1'b1, 1'b0, 32'h0000_0600, 32'h1234_5678, 3'(1 << SECTION_UPPER));
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b10 || memory_write_sections !== 3'b100
            || memory_write_value !== 32'h1234_5678 || memory_address !== 32'h0000_0600) begin
            n_errors++;
            $display("FAIL write_pass: got ready=%b sect=%b wval=%h addr=%h, required 10/100/12345678/00000600",
                     bus.req_ready, memory_write_sections, memory_write_value, memory_address);
        end
        push_exp(1'b1, 32'h0000_0600);
        step();
        drain("write");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_starvation();
        test_saturation();
        test_idle_write();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
